// File: rtl/acc_pkg.sv
// Shared types and defaults for the accumulator operand feeder.
package acc_pkg;

  localparam int ACC_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } acc_feed_state_t;

endpackage

// File: rtl/acc_fifo.sv
// Synchronous FIFO with wrap-bit pointers; no write-to-read bypass,
// so a word pushed this cycle becomes visible at the head next cycle.
module acc_fifo
  import acc_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;

  // Pointer update; the extra top bit separates full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  assign count = wr_ptr_r - rd_ptr_r;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == (AW+1)'(0));
  assign dout  = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/acc_feeder.sv
// Feeds buffered operands to the Accumulator in programmed batches.
// Defining ACC_FEED_SUM_EN adds the issued_sum running-sum port.
module acc_feeder
  import acc_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   start,
  input  logic [CNT_W-1:0]       batch_len,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_W-1:0]      acc_data,
  output logic                   acc_enable,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef ACC_FEED_SUM_EN
  ,
  output logic [DATA_W-1:0]      issued_sum
`endif
);

  acc_feed_state_t   state_r;
  acc_feed_state_t   next_state_s;
  logic [CNT_W-1:0]  remaining_r;
  logic              push_s;
  logic              pop_s;
  logic              load_s;
  logic              full_s;
  logic              empty_s;
  logic [DATA_W-1:0] head_s;
  logic [DATA_W-1:0] acc_data_r;
  logic              acc_enable_r;
  logic              done_r;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_s = in_valid && !full_s;

  acc_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push_s),
    .pop  (pop_s),
    .din  (in_data),
    .dout (head_s),
    .count(fifo_count),
    .full (full_s),
    .empty(empty_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode; the final pop of a batch heads straight to DONE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (batch_len != {CNT_W{1'b0}}) begin
            next_state_s = RUN;
          end else begin
            next_state_s = DONE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (!empty_s && (remaining_r == CNT_W'(1))) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM control outputs.
  always_comb begin
    pop_s  = 1'b0;
    load_s = 1'b0;
    case (state_r)
      IDLE:    load_s = start && (batch_len != {CNT_W{1'b0}});
      RUN:     pop_s  = !empty_s;
      DONE:    pop_s  = 1'b0;
      default: pop_s  = 1'b0;
    endcase
  end

  // Batch counter and registered accumulator-facing outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining_r  <= {CNT_W{1'b0}};
      acc_data_r   <= {DATA_W{1'b0}};
      acc_enable_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      if (load_s) begin
        remaining_r <= batch_len;
      end else if (pop_s && (remaining_r != {CNT_W{1'b0}})) begin
        remaining_r <= remaining_r - CNT_W'(1);
      end
      if (pop_s) begin
        acc_data_r <= head_s;
      end
      acc_enable_r <= pop_s;
      done_r       <= (state_r == DONE);
    end
  end

`ifdef ACC_FEED_SUM_EN
  logic [DATA_W-1:0] sum_r;

  // Running sum tracks what the downstream accumulator will hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_r <= {DATA_W{1'b0}};
    end else if (pop_s) begin
      sum_r <= sum_r + head_s;
    end
  end

  assign issued_sum = sum_r;
`endif

  assign in_ready   = !full_s;
  assign busy       = (state_r != IDLE);
  assign done       = done_r;
  assign acc_data   = acc_data_r;
  assign acc_enable = acc_enable_r;

endmodule
